imem_loader: RTL
================

Name: imem_loader

Overview:
- Hardware program loader: the writer side of the instruction-memory interface that the CPU fetch path reads.
- Takes a framed byte stream (header, then instruction words) and writes each assembled word into the instruction memory.
- Holds the CPU in reset until the whole image is written.
- Replaces simulation-time memory preloading, so the same programs run on silicon.

Parameters:
- IM_AW, 10, instruction-memory word-address width (depth = 2^IM_AW words).
- TEXT_BASE, 32'h0000_3000, byte address of word 0; used only for the load_pc output.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle restart request; honoured only in DONE or ERR.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  IM_AW  word index written.
- im_wdata  out  32  word written.
- cpu_rst  out  1  active-high reset to the CPU; high while loading or in error.
- done  out  1  image fully loaded.
- err  out  1  header word count exceeds memory depth.
- words_loaded  out  16  count of words written since the last (re)start.
- load_pc  out  32  TEXT_BASE, constant; the CPU reset PC.

Behaviour:
- Reset: asynchronous on rst_n low. State HDR_HI; in_ready=0 during reset, then 1.
- Reset values: im_we=0, im_addr=0, im_wdata=0, words_loaded=0, done=0, err=0, cpu_rst=1.
- Frame format:
  - 2-byte word count N, big-endian (high byte first).
  - Then N words, 4 bytes each, big-endian (first byte goes to im_wdata[31:24]).
- Byte transfer: a byte is accepted on a clock edge where in_valid && in_ready.
  - in_valid low inserts wait cycles with no state change.
  - in_data is ignored when no byte is accepted.
- States:
  - HDR_HI: in_ready=1. On accept, latch N[15:8] and go to HDR_LO.
  - HDR_LO: in_ready=1. On accept, latch N[7:0], clear the byte counter, then:
    - N == 0: go to DONE.
    - N > 2^IM_AW: go to ERR.
    - otherwise: go to DATA.
  - DATA: in_ready=1. Shift each accepted byte into the word register. On the 4th byte go to WRITE.
  - WRITE: in_ready=0 for one cycle.
    - im_we=1, im_addr=word index, im_wdata=assembled word.
    - On exit, word index and words_loaded increment.
    - If words_loaded+1 == N go to DONE, else go to DATA.
  - DONE: in_ready=0, done=1, cpu_rst=0. The cycle after the final WRITE, cpu_rst falls and done rises together.
  - ERR: in_ready=0, err=1, cpu_rst=1, no memory writes.
- start in DONE or ERR:
  - Next state is HDR_HI.
  - done, err and words_loaded clear; cpu_rst=1 in the same next cycle.
  - Memory contents are not cleared.
- start in any other state is ignored.
- im_we is high only in WRITE, so exactly one pulse per word.
  - Worst-case throughput is 5 cycles per word (4 accepts + 1 write).
- im_addr and im_wdata hold their last values when im_we=0.
- Word index wraps never: N is bounded by 2^IM_AW. N == 2^IM_AW is legal and fills addresses 0..2^IM_AW-1.
- Reset mid-frame: the partial word is discarded and no write is issued; the next frame starts at HDR_HI.
- The bytes of a partial frame that never completes stay pending forever: loader waits in DATA, cpu_rst stays 1.

Test Plan:
- Load 3 words: stream 00 03 | 20 08 00 05 | 20 09 00 0C | AC 08 00 50.
  - -> im_we pulses at addr 0,1,2 with 0x20080005, 0x2009000C, 0xAC080050.
  - -> done=1 and cpu_rst=0 the cycle after the 3rd write; words_loaded=3.
- Zero-length frame: 00 00 -> no im_we; done=1 and cpu_rst=0 one cycle after the 2nd byte.
- Overflow: IM_AW=10, header 04 01 (N=1025) -> err=1, in_ready=0, cpu_rst=1, no im_we.
  - Then start pulse -> err=0, state HDR_HI, in_ready=1.
- Stalled stream: 1-word frame with random in_valid gaps of 0-7 cycles.
  - -> single write of the correct word; in_ready=0 only during the WRITE cycle.
- Reset mid-word: assert rst_n=0 after 2 data bytes, release, then send a fresh 1-word frame 00 01 | 12 34 56 78.
  - -> one write at addr 0 of 0x12345678; no write of the partial word.
- Restart after DONE: start pulse, then a 2-word frame.
  - -> cpu_rst rises the cycle after start; writes at addr 0,1; words_loaded=2; done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream (16-bit word count, then big-endian
// 32-bit words) into instruction-memory writes, holding the CPU in reset until done.
module imem_loader #(
  parameter int          IM_AW     = 10,
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             err,
  output logic [15:0]      words_loaded,
  output logic [31:0]      load_pc
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // Widened by one bit so that N == 2^IM_AW is representable as the legal maximum.
  localparam logic [16:0] DEPTH = 17'd1 << IM_AW;

  state_t             state_r;
  state_t             state_s;
  logic               accept_s;
  logic [15:0]        n_s;
  logic [7:0]         n_hi_r;
  logic [15:0]        n_r;
  logic [1:0]         cnt_r;
  logic [23:0]        word_r;
  logic [IM_AW-1:0]   idx_r;
  logic [15:0]        wl_r;
  logic               in_ready_r;
  logic               im_we_r;
  logic [IM_AW-1:0]   im_addr_r;
  logic [31:0]        im_wdata_r;
  logic               cpu_rst_r;
  logic               done_r;
  logic               err_r;

  assign accept_s = in_valid && in_ready_r;
  assign n_s      = {n_hi_r, in_data};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_HDR_HI;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_HDR_HI: begin
        if (accept_s) state_s = S_HDR_LO;
        else          state_s = S_HDR_HI;
      end
      S_HDR_LO: begin
        if (!accept_s)                 state_s = S_HDR_LO;
        else if (n_s == 16'd0)         state_s = S_DONE;
        else if ({1'b0, n_s} > DEPTH)  state_s = S_ERR;
        else                           state_s = S_DATA;
      end
      S_DATA: begin
        if (accept_s && (cnt_r == 2'd3)) state_s = S_WRITE;
        else                             state_s = S_DATA;
      end
      S_WRITE: begin
        if ((wl_r + 16'd1) == n_r) state_s = S_DONE;
        else                       state_s = S_DATA;
      end
      S_DONE: begin
        if (start) state_s = S_HDR_HI;
        else       state_s = S_DONE;
      end
      S_ERR: begin
        if (start) state_s = S_HDR_HI;
        else       state_s = S_ERR;
      end
      default: state_s = S_HDR_HI;
    endcase
  end

  // Header capture, word assembly and write-index bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_hi_r     <= 8'd0;
      n_r        <= 16'd0;
      cnt_r      <= 2'd0;
      word_r     <= 24'd0;
      idx_r      <= '0;
      wl_r       <= 16'd0;
      im_addr_r  <= '0;
      im_wdata_r <= 32'd0;
    end else begin
      case (state_r)
        S_HDR_HI: begin
          if (accept_s) n_hi_r <= in_data;
        end
        S_HDR_LO: begin
          if (accept_s) begin
            n_r   <= n_s;
            cnt_r <= 2'd0;
            idx_r <= '0;
          end
        end
        S_DATA: begin
          if (accept_s) begin
            word_r <= {word_r[15:0], in_data};
            cnt_r  <= cnt_r + 2'd1;
            // Present the completed word together with the strobe in WRITE.
            if (cnt_r == 2'd3) begin
              im_wdata_r <= {word_r, in_data};
              im_addr_r  <= idx_r;
            end
          end
        end
        S_WRITE: begin
          idx_r <= idx_r + IM_AW'(1);
          wl_r  <= wl_r + 16'd1;
        end
        S_DONE, S_ERR: begin
          if (start) begin
            idx_r <= '0;
            wl_r  <= 16'd0;
          end
        end
        default: begin
          cnt_r <= 2'd0;
        end
      endcase
    end
  end

  // Registered status/strobe outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b0;
      im_we_r    <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      cpu_rst_r  <= 1'b1;
    end else begin
      in_ready_r <= (state_s == S_HDR_HI) || (state_s == S_HDR_LO) || (state_s == S_DATA);
      im_we_r    <= (state_s == S_WRITE);
      done_r     <= (state_s == S_DONE);
      err_r      <= (state_s == S_ERR);
      cpu_rst_r  <= (state_s != S_DONE);
    end
  end

  assign in_ready     = in_ready_r;
  assign im_we        = im_we_r;
  assign im_addr      = im_addr_r;
  assign im_wdata     = im_wdata_r;
  assign cpu_rst      = cpu_rst_r;
  assign done         = done_r;
  assign err          = err_r;
  assign words_loaded = wl_r;
  assign load_pc      = TEXT_BASE;

endmodule
